uart_rx_shift_top: RTL and testbench

UART receive datapath: samples the serial line `rx_data` with a 16x oversampling tick, detects the start bit, and shifts in eight data bits LSB-first. After a valid stop bit it presents the byte on `output_data` with a one-cycle `done` pulse. It sits between the RX pin synchronizer and the receive buffer/LSU interface. It generates its own oversampling tick `baud_clk` from `clk`.

---
 rtl/uart_rx_shift_if.sv | 20 ++
 rtl/uart_rx_shift_top.sv | 123 ++++++++++++
 tb/tb_uart_rx_shift_top.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_shift_if.sv
// Serial-in / parallel-out signal bundle between the RX pin side and the receive buffer.
interface uart_rx_shift_if;
  logic       rx_data;
  logic       baud_clk;
  logic       Shift;
  logic       done;
  logic [7:0] output_data;
  logic [3:0] count_rep;
  logic [3:0] count_bits;

  modport master (
    output rx_data,
    input  baud_clk, Shift, done, output_data, count_rep, count_bits
  );

  modport slave (
    input  rx_data,
    output baud_clk, Shift, done, output_data, count_rep, count_bits
  );
endinterface

// File: rtl/uart_rx_shift_top.sv
// UART receive datapath: 16x oversampled start detect, LSB-first 8-bit shift-in, stop check.
module uart_rx_shift_top #(
  parameter int unsigned BAUD_DIV   = 4,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_shift_if.slave rx_if
);

  localparam int unsigned      DIV_W     = $clog2(BAUD_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [3:0]       REP_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]       REP_MID   = 4'((OVERSAMPLE / 2) - 1);
  localparam logic [3:0]       BITS_LAST = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [3:0]       rep_q;
  logic [3:0]       rep_inc;
  logic [3:0]       bits_q;
  logic [7:0]       sr_q;
  logic [7:0]       sr_next;
  logic [7:0]       out_q;
  logic             done_q;
  logic             tick;
  logic             shift_c;

  // Oversampling tick decode and divider next value
  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    rep_inc = rep_q + 4'd1;
    shift_c = tick && (state_q == S_DATA) && (rep_q == REP_LAST);
    sr_next = shift_c ? {rx_if.rx_data, sr_q[7:1]} : sr_q;
  end

  // Tick divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Receive FSM, counters, shift register and output byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rep_q   <= 4'd0;
      bits_q  <= 4'd0;
      sr_q    <= 8'h00;
      out_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      sr_q   <= sr_next;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            rep_q  <= 4'd0;
            bits_q <= 4'd0;
            if (!rx_if.rx_data) begin
              state_q <= S_START;
              sr_q    <= 8'h00;
            end
          end
          S_START: begin
            // The detect tick counts as tick 0, so the mid-bit check uses the incremented count.
            if (rep_inc == REP_MID) begin
              rep_q   <= 4'd0;
              state_q <= rx_if.rx_data ? S_IDLE : S_DATA;
            end else begin
              rep_q <= rep_inc;
            end
          end
          S_DATA: begin
            if (rep_q == REP_LAST) begin
              rep_q  <= 4'd0;
              bits_q <= bits_q + 4'd1;
              if (bits_q == BITS_LAST) begin
                state_q <= S_STOP;
              end
            end else begin
              rep_q <= rep_inc;
            end
          end
          S_STOP: begin
            if (rep_q == REP_LAST) begin
              rep_q   <= 4'd0;
              bits_q  <= 4'd0;
              state_q <= S_IDLE;
              if (rx_if.rx_data) begin
                out_q  <= sr_q;
                done_q <= 1'b1;
              end
            end else begin
              rep_q <= rep_inc;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_if.baud_clk    = tick;
  assign rx_if.Shift       = shift_c;
  assign rx_if.done        = done_q;
  assign rx_if.output_data = out_q;
  assign rx_if.count_rep   = rep_q;
  assign rx_if.count_bits  = bits_q;

endmodule

// File: tb/tb_uart_rx_shift_top.sv
// Scoreboard bench for uart_rx_shift_top: frame stimulus pushes expected bytes, a monitor checks them.
module tb_uart_rx_shift_top;

  localparam int unsigned BAUD_DIV = 4;
  localparam int unsigned BIT_CYC  = 16 * BAUD_DIV;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_rx_shift_if rx_if ();

  uart_rx_shift_top #(
    .BAUD_DIV  (BAUD_DIV),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx_if(rx_if)
  );

  always #5 clk = ~clk;

  int         checks      = 0;
  int         failures    = 0;
  int         shift_seen  = 0;
  int         done_seen   = 0;
  int         exp_shifts  = 0;
  int         gap         = 0;
  bit         have_prev   = 1'b0;
  logic [7:0] model_out   = 8'h00;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Line is idle for pre bit-times, then start, 8 data bits LSB-first, stop.
  // A bad stop is held low long enough to be sampled but released before it could pass as a start bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int pre);
    if (stop_ok) exp_q.push_back(b);
    exp_shifts += 8;
    rx_if.rx_data = 1'b1;
    wait_cycles(pre * BIT_CYC);
    rx_if.rx_data = 1'b0;
    wait_cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx_if.rx_data = b[i];
      wait_cycles(BIT_CYC);
    end
    if (stop_ok) begin
      rx_if.rx_data = 1'b1;
      wait_cycles(BIT_CYC);
    end else begin
      rx_if.rx_data = 1'b0;
      wait_cycles(10 * BAUD_DIV);
      rx_if.rx_data = 1'b1;
      wait_cycles(6 * BAUD_DIV);
    end
  endtask

  // Monitor: reset values, tick spacing, pulse exclusivity, byte scoreboard and output hold
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ({rx_if.baud_clk, rx_if.Shift, rx_if.done, rx_if.output_data,
           rx_if.count_rep, rx_if.count_bits} !== 19'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%h want=0",
                 {rx_if.baud_clk, rx_if.Shift, rx_if.done, rx_if.output_data,
                  rx_if.count_rep, rx_if.count_bits});
      end
      model_out = 8'h00;
      have_prev = 1'b0;
      gap       = 0;
    end else begin
      gap++;
      if (rx_if.baud_clk) begin
        if (have_prev) begin
          checks++;
          if (gap != BAUD_DIV) begin
            failures++;
            $display("FAIL baud_period got=%0d want=%0d", gap, BAUD_DIV);
          end
        end
        have_prev = 1'b1;
        gap       = 0;
      end
      checks++;
      if (rx_if.Shift && rx_if.done) begin
        failures++;
        $display("FAIL shift_done_overlap got=1 want=0");
      end
      checks++;
      if (rx_if.count_bits > 4'd8) begin
        failures++;
        $display("FAIL count_bits_range got=%0d want<=8", rx_if.count_bits);
      end
      if (rx_if.Shift) shift_seen++;
      if (rx_if.done) begin
        done_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done got=%h want=none", rx_if.output_data);
        end else begin
          model_out = exp_q.pop_front();
          if (rx_if.output_data !== model_out) begin
            failures++;
            $display("FAIL rx_byte got=%h want=%h", rx_if.output_data, model_out);
          end
        end
      end else begin
        checks++;
        if (rx_if.output_data !== model_out) begin
          failures++;
          $display("FAIL output_hold got=%h want=%h", rx_if.output_data, model_out);
        end
      end
    end
  end

  // Time limit
  initial begin
    #1_000_000;
    $display("FAIL timeout got=running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int s0;
    int d0;
    rx_if.rx_data = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cycles(2 * BIT_CYC);
    check_eq("idle_count_rep", int'(rx_if.count_rep), 0);
    check_eq("idle_count_bits", int'(rx_if.count_bits), 0);

    // Frame A then frame B right behind it
    s0 = shift_seen; d0 = done_seen;
    send_frame(8'h6B, 1'b1, 2);
    check_eq("frameA_shifts", shift_seen - s0, 8);
    check_eq("frameA_done", done_seen - d0, 1);
    s0 = shift_seen; d0 = done_seen;
    send_frame(8'h73, 1'b1, 2);
    check_eq("frameB_shifts", shift_seen - s0, 8);
    check_eq("frameB_done", done_seen - d0, 1);
    s0 = shift_seen; d0 = done_seen;
    send_frame(8'hA5, 1'b1, 0);
    check_eq("back2back_done", done_seen - d0, 1);

    // Start glitch
    wait_cycles(BIT_CYC);
    s0 = shift_seen; d0 = done_seen;
    rx_if.rx_data = 1'b0;
    wait_cycles(4 * BAUD_DIV);
    rx_if.rx_data = 1'b1;
    wait_cycles(2 * BIT_CYC);
    check_eq("glitch_shifts", shift_seen - s0, 0);
    check_eq("glitch_done", done_seen - d0, 0);
    check_eq("glitch_count_bits", int'(rx_if.count_bits), 0);
    check_eq("glitch_count_rep", int'(rx_if.count_rep), 0);

    // Framing error
    s0 = shift_seen; d0 = done_seen;
    send_frame(8'h6B, 1'b0, 1);
    wait_cycles(BIT_CYC);
    check_eq("ferr_shifts", shift_seen - s0, 8);
    check_eq("ferr_done", done_seen - d0, 0);

    // Mid-frame reset after data bit 3
    s0 = shift_seen; d0 = done_seen;
    rx_if.rx_data = 1'b0;
    wait_cycles(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      rx_if.rx_data = (i == 2) ? 1'b0 : 1'b1;
      wait_cycles(BIT_CYC);
    end
    exp_shifts += 4;
    check_eq("midreset_shifts", shift_seen - s0, 4);
    check_eq("midreset_count_bits_pre", int'(rx_if.count_bits), 4);
    reset = 1'b0;
    #1;
    check_eq("midreset_count_bits", int'(rx_if.count_bits), 0);
    check_eq("midreset_count_rep", int'(rx_if.count_rep), 0);
    check_eq("midreset_output", int'(rx_if.output_data), 0);
    rx_if.rx_data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cycles(BIT_CYC);
    check_eq("midreset_no_done", done_seen - d0, 0);
    d0 = done_seen;
    send_frame(8'h6B, 1'b1, 1);
    check_eq("postreset_done", done_seen - d0, 1);

    // Random frames
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      bit         ok;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, int'($urandom_range(1, 2)));
    end

    wait_cycles(2 * BIT_CYC);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("total_shifts", shift_seen, exp_shifts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
